// File: rtl/bus_mem_responder.sv
// Memory responder on the far end of the ibus/dbus request interfaces.
// Both ports share one word-addressed RAM; each port runs an independent
// IDLE -> WAIT -> RESP handshake with its own programmable latency.

package bus_mem_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

// Per-port request/response sequencer.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for req_valid; captures address on acceptance
// WAIT   | latency down-counter running; RESP follows the count of 1
// RESP   | one-cycle addr_ok/data_ok pulse with the registered word
module bus_mem_port #(
  parameter logic [63:0] BASE        = 64'h8000_0000,
  parameter int          DEPTH_WORDS = 65536,
  parameter int          LATENCY     = 2,
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic [63:0]   req_addr,
  input  logic [63:0]   rd_word,
  output logic [AW-1:0] rd_idx,
  output logic          capture,
  output logic          err_set,
  output logic          resp_state,
  output logic          resp_oor,
  output logic          resp_ok,
  output logic [63:0]   resp_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY);

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          oor_q, oor_d;
  logic          ok_q, ok_d;
  logic [63:0]   data_q, data_d;

  logic [63:0]   req_off;
  logic          req_oor;
  logic          unused_off_lsb;

  // Offset from BASE; anything below BASE wraps to a huge offset and is
  // caught by the explicit compare as well.
  assign req_off        = req_addr - BASE;
  assign req_oor        = (req_addr < BASE) || (req_off[63:AW+3] != '0);
  assign unused_off_lsb = ^req_off[2:0];

  // In IDLE the live request drives the RAM index so a zero-latency
  // response can be read on the acceptance edge.
  assign rd_idx     = (state_q == S_IDLE) ? req_off[AW+2:3] : idx_q;
  assign err_set    = capture && req_oor;
  assign resp_state = (state_q == S_RESP);
  assign resp_oor   = oor_q;
  assign resp_ok    = ok_q;
  assign resp_data  = data_q;

  // Next-state, counter and response computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    oor_d   = oor_q;
    ok_d    = 1'b0;
    data_d  = data_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          idx_d   = req_off[AW+2:3];
          oor_d   = req_oor;
          if (LATENCY == 0) begin
            state_d = S_RESP;
            ok_d    = 1'b1;
            data_d  = req_oor ? '0 : rd_word;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = S_RESP;
          ok_d    = 1'b1;
          data_d  = oor_q ? '0 : rd_word;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state, counter, captured request and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      ok_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      oor_q   <= oor_d;
      ok_q    <= ok_d;
      data_q  <= data_d;
    end
  end

endmodule

module bus_mem_responder
  import bus_mem_pkg::*;
#(
  parameter logic [63:0] BASE        = 64'h8000_0000,
  parameter int          DEPTH_WORDS = 65536,
  parameter int          I_LATENCY   = 2,
  parameter int          D_LATENCY   = 3,
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       err
);

  logic [63:0]   mem [DEPTH_WORDS];

  logic [AW-1:0] i_rd_idx, d_rd_idx;
  logic [63:0]   i_rd_word, d_rd_word;
  logic          i_err_set, d_err_set;
  logic          i_ok, d_ok;
  logic [63:0]   i_data, d_data;
  logic          d_capture, d_resp_state, d_resp_oor;
  logic          unused_i_capture, unused_i_resp_state, unused_i_resp_oor;
  logic          unused_size;

  logic [7:0]    strobe_q, strobe_d;
  logic [63:0]   wdata_q, wdata_d;
  logic          err_q, err_d;
  logic          mem_we;

  // Transfer size is informational only; the strobe selects the lanes.
  assign unused_size = ^dreq.size;

  assign i_rd_word = mem[i_rd_idx];
  assign d_rd_word = mem[d_rd_idx];

  bus_mem_port #(
    .BASE        (BASE),
    .DEPTH_WORDS (DEPTH_WORDS),
    .LATENCY     (I_LATENCY)
  ) u_iport (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (ireq.valid),
    .req_addr   (ireq.addr),
    .rd_word    (i_rd_word),
    .rd_idx     (i_rd_idx),
    .capture    (unused_i_capture),
    .err_set    (i_err_set),
    .resp_state (unused_i_resp_state),
    .resp_oor   (unused_i_resp_oor),
    .resp_ok    (i_ok),
    .resp_data  (i_data)
  );

  bus_mem_port #(
    .BASE        (BASE),
    .DEPTH_WORDS (DEPTH_WORDS),
    .LATENCY     (D_LATENCY)
  ) u_dport (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (dreq.valid),
    .req_addr   (dreq.addr),
    .rd_word    (d_rd_word),
    .rd_idx     (d_rd_idx),
    .capture    (d_capture),
    .err_set    (d_err_set),
    .resp_state (d_resp_state),
    .resp_oor   (d_resp_oor),
    .resp_ok    (d_ok),
    .resp_data  (d_data)
  );

  assign iresp = '{addr_ok: i_ok, data_ok: i_ok, data: i_data};
  assign dresp = '{addr_ok: d_ok, data_ok: d_ok, data: d_data};
  assign err   = err_q;

  // Store payload is held from acceptance; the write lands on the edge
  // that ends RESP so the response carries the pre-store word.
  assign mem_we = d_resp_state && !d_resp_oor && (strobe_q != '0);

  // Captured store payload and sticky out-of-range flag.
  always_comb begin
    strobe_d = d_capture ? dreq.strobe : strobe_q;
    wdata_d  = d_capture ? dreq.data   : wdata_q;
    err_d    = err_q | i_err_set | d_err_set;
  end

  // Store payload and error flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_q <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      strobe_q <= strobe_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

  // Byte-lane RAM write; contents survive reset, a store in flight does not.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      for (int k = 0; k < 8; k++) begin
        if (strobe_q[k]) begin
          mem[d_rd_idx][8*k +: 8] <= wdata_q[8*k +: 8];
        end
      end
    end
  end

endmodule
